ahb_arbiter: RTL
================

Name: ahb_arbiter

Overview:
- Arbitrates up to NUM_MASTERS AHB masters for the shared bus in front of ahb_slave; drives one-hot hgrant, registered hmaster (select for the address/control mux) and hmastlock.
- Round-robin among requesters. Never re-grants inside a fixed-length burst or a locked sequence.
- Parks on DEFAULT_MASTER when nobody requests.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..4).
- DEFAULT_MASTER, 0, index granted at reset and when the bus is parked.

Ports:
- hclk  input  1  bus clock
- hresetn  input  1  reset, asynchronous, active-high (asserted = 1)
- hbusreq  input  NUM_MASTERS  per-master bus request
- hlock  input  NUM_MASTERS  per-master locked-transfer request
- htrans  input  2  transfer type of the current bus owner (muxed)
- hburst  input  3  burst type of the current bus owner (muxed)
- hready  input  1  bus ready (from the slave hreadyout mux)
- hgrant  output  NUM_MASTERS  one-hot grant
- hmaster  output  2  index of the master owning the address phase
- hmastlock  output  1  current address phase is locked

Behaviour:
- Reset (async, hresetn=1):
  - hgrant = 1<<DEFAULT_MASTER; hmaster = DEFAULT_MASTER; hmastlock = 0.
  - state = PARK; beat_cnt = 0; rr_ptr = DEFAULT_MASTER.
  - Reset mid-burst aborts immediately. No state survives.
- All outputs are registered. hgrant is always exactly one-hot.
- Ownership handover:
  - hmaster <= index(hgrant) and hmastlock <= hlock[index(hgrant)] on every posedge with hready=1.
  - hmaster/hmastlock hold while hready=0.
- Arbitration point (ARB): hready=1 and one of:
  - state PARK;
  - state OWN and htrans==IDLE(00);
  - state OWN and htrans==NONSEQ(10) with hburst==SINGLE(000);
  - state BURST and beat_cnt==1 with htrans==SEQ(11), i.e. the last beat is accepted.
- At ARB, hgrant is updated on the next edge:
  - Winner = first master with hbusreq=1, searching rr_ptr+1, rr_ptr+2, ... mod NUM_MASTERS, current owner checked last.
  - rr_ptr <= winner.
  - No requests: grant DEFAULT_MASTER, go PARK.
- FSM:
  - PARK: any hbusreq -> OWN with winner.
  - OWN:
    - owner hlock=1 -> LOCK.
    - NONSEQ with hready=1 and hburst in {INCR4/WRAP4 (011/010), INCR8/WRAP8 (101/100), INCR16/WRAP16 (111/110)} -> BURST, beat_cnt <= 3/7/15.
    - INCR(001) is undefined length: stays OWN, re-arbitrable only at IDLE.
  - BURST:
    - beat_cnt decrements on SEQ with hready=1; holds on BUSY(01) or hready=0.
    - When beat_cnt==1 and the SEQ is accepted: ARB, then OWN (or PARK).
    - Owner issues NONSEQ/IDLE early (burst early termination): beat_cnt <= 0, -> OWN, evaluated as an OWN ARB in the same cycle.
  - LOCK:
    - No re-arbitration while owner hlock=1.
    - Owner hlock=0, htrans==IDLE and hready=1 -> ARB.
- Simultaneous events:
  - New requests during BURST/LOCK are ignored until ARB.
  - Owner dropping hbusreq mid-burst does not end the burst.
  - hlock takes precedence over the burst counter: a locked burst stays in LOCK and is counted only by hlock/IDLE.
- Width rules:
  - beat_cnt is 4 bits.
  - hmaster upper bits are 0 when NUM_MASTERS<4.
  - Masters with index >= NUM_MASTERS are never granted.

Decomposition:
- Package ahb_pkg:
  - HTRANS constants IDLE/BUSY/NONSEQ/SEQ.
  - HBURST constants SINGLE..INCR16.
  - Arbiter state encoding PARK/OWN/BURST/LOCK.
  - Function burst_len(hburst) returning 0/3/7/15.
  - ahb_pkg is shared with ahb_slave and the future master.
- Sub-module ahb_rr_picker: combinational, takes req vector + rr_ptr, returns valid + winner index.

Test Plan:
- Reset with hbusreq=0000 -> hgrant=0001, hmaster=0, hmastlock=0; remains after release while idle.
- hbusreq=0110, master1 issues SINGLE NONSEQ then IDLE -> grant 0010 first, then 0100 on the next ARB; hbusreq=1111 held -> grant sequence 1,2,3,0,1 (round-robin fairness).
- Master2 INCR4 NONSEQ+3 SEQ with hbusreq=1111 and one hready=0 stall on beat 2 -> hgrant stays 0100 until the 4th beat is accepted, then 1000; hmaster changes exactly one hready-high edge later.
- Master3 hlock=1 over INCR8, others requesting -> hgrant=1000 and hmastlock=1 throughout; released only after hlock=0 and htrans=IDLE.
- INCR16 terminated by NONSEQ after 5 beats -> counter cleared, immediate OWN ARB, next requester granted.
- hresetn asserted mid-INCR8 -> same cycle hgrant=0001, hmaster=0, hmastlock=0; after release, a fresh request is arbitrated normally.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB definitions for the arbiter, ahb_slave and bus masters.
//   HTRANS_*  : transfer type encodings
//   HBURST_*  : burst type encodings
//   ARB_*     : arbiter FSM state encoding
//   burst_len : beats remaining after the NONSEQ of a fixed-length burst
//   oh_idx    : index of the set bit in a 4-bit one-hot vector
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] ARB_PARK  = 2'd0;
    localparam logic [1:0] ARB_OWN   = 2'd1;
    localparam logic [1:0] ARB_BURST = 2'd2;
    localparam logic [1:0] ARB_LOCK  = 2'd3;

    // SINGLE and INCR have no fixed length and return 0.
    function automatic logic [3:0] burst_len(input logic [2:0] hburst);
        logic [3:0] len;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  len = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  len = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: len = 4'd15;
            default:                      len = 4'd0;
        endcase
        return len;
    endfunction

    function automatic logic [1:0] oh_idx(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: arbitration signals between the masters and the arbiter.
//   hbusreq/hlock : per-master request and lock request
//   htrans/hburst : muxed transfer/burst type of the current bus owner
//   hready        : muxed slave ready
//   hgrant/hmaster/hmastlock : arbiter outputs
// modport master: bus masters side; modport slave: arbiter side.
interface ahb_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic [2:0]             hburst;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [1:0]             hmaster;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: combinational round-robin selector.
//   req    : request vector, one bit per master
//   rr_ptr : last winner; search starts at rr_ptr+1 and checks rr_ptr last
//   valid  : at least one request present
//   winner : index of the selected master
module ahb_rr_picker #(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             rr_ptr,
    output logic                   valid,
    output logic [1:0]             winner
);

    logic [3:0] req_pad;
    assign req_pad = 4'(req);

    always_comb begin
        int unsigned sum;
        logic [1:0]  cand;
        valid  = 1'b0;
        winner = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            sum = 32'(rr_ptr) + i;
            if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
            cand = 2'(sum);
            if (!valid && req_pad[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with burst and lock protection.
//   hclk    : bus clock
//   hresetn : asynchronous reset, active high
//   bus     : ahb_arbiter_if.slave (requests, muxed htrans/hburst/hready in;
//             one-hot hgrant, registered hmaster and hmastlock out)
// Parks on DEFAULT_MASTER when idle; never re-grants inside a fixed-length
// burst or while the owner holds hlock.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic           hclk,
    input  logic           hresetn,
    ahb_arbiter_if.slave   bus
);

    localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MASTER);
    localparam logic [3:0] DEF_OH  = 4'b0001 << DEFAULT_MASTER;

    logic [1:0]             state_q,     state_d;
    logic [3:0]             beat_cnt_q,  beat_cnt_d;
    logic [1:0]             rr_ptr_q,    rr_ptr_d;
    logic [NUM_MASTERS-1:0] hgrant_q,    hgrant_d;
    logic [1:0]             hmaster_q,   hmaster_d;
    logic                   hmastlock_q, hmastlock_d;

    logic       pick_valid;
    logic [1:0] pick_winner;
    logic [1:0] owner;
    logic       owner_lock;
    logic [3:0] lock_pad;
    logic [3:0] win_oh;
    logic [3:0] len;
    logic       arb;

    ahb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .req    (bus.hbusreq),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Owner is the currently granted master.
    assign owner      = oh_idx(4'(hgrant_q));
    assign lock_pad   = 4'(bus.hlock);
    assign owner_lock = lock_pad[owner];
    assign win_oh     = 4'b0001 << pick_winner;
    assign len        = burst_len(bus.hburst);

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        hgrant_d    = hgrant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        arb         = 1'b0;

        if (bus.hready) begin
            hmaster_d   = owner;
            hmastlock_d = owner_lock;
        end

        case (state_q)
            ARB_PARK: arb = bus.hready;
            ARB_OWN: begin
                if (owner_lock) begin
                    state_d = ARB_LOCK;
                end else if (bus.hready) begin
                    if (bus.htrans == HTRANS_IDLE ||
                        (bus.htrans == HTRANS_NONSEQ && bus.hburst == HBURST_SINGLE)) begin
                        arb = 1'b1;
                    end else if (bus.htrans == HTRANS_NONSEQ && len != 4'd0) begin
                        state_d    = ARB_BURST;
                        beat_cnt_d = len;
                    end
                end
            end
            ARB_BURST: begin
                // Lock wins over the beat counter.
                if (owner_lock) begin
                    state_d    = ARB_LOCK;
                    beat_cnt_d = '0;
                end else if (bus.hready) begin
                    case (bus.htrans)
                        HTRANS_SEQ: begin
                            if (beat_cnt_q == 4'd1) begin
                                beat_cnt_d = '0;
                                arb        = 1'b1;
                            end else begin
                                beat_cnt_d = beat_cnt_q - 4'd1;
                            end
                        end
                        // Early termination: treated as an OWN arbitration point.
                        HTRANS_IDLE, HTRANS_NONSEQ: begin
                            beat_cnt_d = '0;
                            state_d    = ARB_OWN;
                            arb        = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ARB_LOCK: begin
                if (!owner_lock && bus.hready && bus.htrans == HTRANS_IDLE) arb = 1'b1;
            end
            default: state_d = ARB_PARK;
        endcase

        if (arb) begin
            if (pick_valid) begin
                hgrant_d = win_oh[NUM_MASTERS-1:0];
                rr_ptr_d = pick_winner;
                state_d  = ARB_OWN;
            end else begin
                hgrant_d = DEF_OH[NUM_MASTERS-1:0];
                state_d  = ARB_PARK;
            end
        end
    end

    always_ff @(posedge hclk or posedge hresetn) begin
        if (hresetn) begin
            state_q     <= ARB_PARK;
            beat_cnt_q  <= '0;
            rr_ptr_q    <= DEF_IDX;
            hgrant_q    <= DEF_OH[NUM_MASTERS-1:0];
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign bus.hgrant    = hgrant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

endmodule
